// File: rtl/mem_stage.sv
// Memory-access stage: drives the data-memory handshake, stalls upstream while
// an access is outstanding, and registers the write-back / branch results.
module mem_stage #(
  parameter int WORD_SIZE = 16,
  parameter int MAX_WAIT  = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] ALU_Result_in,
  input  logic [WORD_SIZE-1:0] r_data1_in,
  input  logic [WORD_SIZE-1:0] r_data2_in,
  input  logic [1:0]           rd_in,
  input  logic                 MemRead_in,
  input  logic                 MemWrite_in,
  input  logic                 RegWrite_in,
  input  logic                 MemtoReg_in,
  input  logic                 is_wwd_in,
  input  logic                 B_OP_in,
  input  logic                 B_cond_in,
  input  logic [WORD_SIZE-1:0] target_address_in,
  output logic                 d_readM,
  output logic                 d_writeM,
  output logic [WORD_SIZE-1:0] d_address,
  output logic [WORD_SIZE-1:0] d_wdata,
  input  logic [WORD_SIZE-1:0] d_rdata,
  input  logic                 d_ready,
  output logic                 mem_stall,
  output logic [WORD_SIZE-1:0] wb_data_out,
  output logic [1:0]           rd_out,
  output logic                 RegWrite_out,
  output logic                 is_wwd_out,
  output logic [WORD_SIZE-1:0] wwd_data_out,
  output logic                 branch_taken,
  output logic [WORD_SIZE-1:0] branch_target,
  output logic                 mem_error
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                 state_q;
  logic [7:0]             cnt_q, cnt_d;
  logic [1:0]             rd_q;
  logic                   regwrite_q, memtoreg_q, is_wwd_q;
  logic [WORD_SIZE-1:0]   wwd_q;
  logic                   mem_op, timeout;

  assign mem_op  = MemRead_in | MemWrite_in;
  assign timeout = (state_q == ACCESS) && !d_ready && (cnt_q == 8'(MAX_WAIT - 1));
  assign cnt_d   = (state_q == IDLE) ? 8'd0 : cnt_q + 8'd1;

  // Upstream holds only while an access is still pending; the completing
  // (ready or abandoned) cycle lets the next instruction advance.
  always_comb begin
    mem_stall = 1'b0;
    if (!reset_n) begin
      if (state_q == IDLE) mem_stall = mem_op;
      else                 mem_stall = !d_ready && !timeout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      rd_q          <= 2'd0;
      regwrite_q    <= 1'b0;
      memtoreg_q    <= 1'b0;
      is_wwd_q      <= 1'b0;
      d_readM       <= 1'b0;
      d_writeM      <= 1'b0;
      d_address     <= '0;
      d_wdata       <= '0;
      wb_data_out   <= '0;
      rd_out        <= 2'd0;
      RegWrite_out  <= 1'b0;
      is_wwd_out    <= 1'b0;
      wwd_data_out  <= '0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
      mem_error     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_op) begin
            d_address    <= ALU_Result_in;
            d_wdata      <= r_data2_in;
            rd_q         <= rd_in;
            regwrite_q   <= RegWrite_in;
            memtoreg_q   <= MemtoReg_in;
            is_wwd_q     <= is_wwd_in;
            wwd_q        <= r_data1_in;
            d_writeM     <= MemWrite_in;
            d_readM      <= MemRead_in & ~MemWrite_in;
            cnt_q        <= cnt_d;
            state_q      <= ACCESS;
            RegWrite_out <= 1'b0;
            is_wwd_out   <= 1'b0;
            branch_taken <= 1'b0;
          end else begin
            wb_data_out   <= ALU_Result_in;
            rd_out        <= rd_in;
            RegWrite_out  <= RegWrite_in;
            is_wwd_out    <= is_wwd_in;
            wwd_data_out  <= r_data1_in;
            branch_taken  <= B_OP_in & B_cond_in;
            branch_target <= target_address_in;
          end
        end
        ACCESS: begin
          if (d_ready) begin
            wb_data_out  <= memtoreg_q ? d_rdata : d_address;
            rd_out       <= rd_q;
            RegWrite_out <= regwrite_q;
            is_wwd_out   <= is_wwd_q;
            wwd_data_out <= wwd_q;
            branch_taken <= 1'b0;
            d_readM      <= 1'b0;
            d_writeM     <= 1'b0;
            state_q      <= IDLE;
          end else if (timeout) begin
            // Abandoned access: the instruction retires as a bubble.
            mem_error    <= 1'b1;
            d_readM      <= 1'b0;
            d_writeM     <= 1'b0;
            RegWrite_out <= 1'b0;
            is_wwd_out   <= 1'b0;
            branch_taken <= 1'b0;
            state_q      <= IDLE;
          end else begin
            cnt_q        <= cnt_d;
            RegWrite_out <= 1'b0;
            is_wwd_out   <= 1'b0;
            branch_taken <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset corner sequences, and a
// randomized instruction stream checked against a transaction-level model.
module tb_mem_stage;

  localparam int W  = 16;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  ALU_Result_in, r_data1_in, r_data2_in, target_address_in, d_rdata;
  logic [1:0]    rd_in;
  logic          MemRead_in, MemWrite_in, RegWrite_in, MemtoReg_in, is_wwd_in, B_OP_in, B_cond_in;
  logic          d_ready;
  logic          d_readM, d_writeM, mem_stall, RegWrite_out, is_wwd_out, branch_taken, mem_error;
  logic [W-1:0]  d_address, d_wdata, wb_data_out, wwd_data_out, branch_target;
  logic [1:0]    rd_out;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_stage #(.WORD_SIZE(W), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset_n(reset_n),
    .ALU_Result_in(ALU_Result_in), .r_data1_in(r_data1_in), .r_data2_in(r_data2_in),
    .rd_in(rd_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .is_wwd_in(is_wwd_in),
    .B_OP_in(B_OP_in), .B_cond_in(B_cond_in), .target_address_in(target_address_in),
    .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .mem_stall(mem_stall),
    .wb_data_out(wb_data_out), .rd_out(rd_out), .RegWrite_out(RegWrite_out),
    .is_wwd_out(is_wwd_out), .wwd_data_out(wwd_data_out),
    .branch_taken(branch_taken), .branch_target(branch_target), .mem_error(mem_error)
  );

  // lat = index of the ACCESS cycle in which memory answers; > MW means never
  typedef struct {
    logic [W-1:0] alu, r1, r2, tgt, rdata;
    logic [1:0]   rd;
    logic         mr, mw, rw, m2r, wwd, bop, bcond;
    int           lat;
  } instr_t;

  typedef struct {
    logic [W-1:0] wb, wdat, tgt;
    logic [1:0]   rd;
    logic         rw, wwd, bt, err;
    int           stall, rcyc, wcyc;
    bit           chk_data, chk_tgt;
  } exp_t;

  typedef struct {
    instr_t in;
    exp_t   ex;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic drive(input instr_t in);
    ALU_Result_in     = in.alu;
    r_data1_in        = in.r1;
    r_data2_in        = in.r2;
    target_address_in = in.tgt;
    d_rdata           = in.rdata;
    rd_in             = in.rd;
    MemRead_in        = in.mr;
    MemWrite_in       = in.mw;
    RegWrite_in       = in.rw;
    MemtoReg_in       = in.m2r;
    is_wwd_in         = in.wwd;
    B_OP_in           = in.bop;
    B_cond_in         = in.bcond;
  endtask

  // Present one instruction (starting 1 time unit after a posedge), hold it
  // while stalled, answer the memory after in.lat ACCESS cycles, then check.
  task automatic exec(input instr_t in, input exp_t ex, input string tag);
    int  stall = 0, rcyc = 0, wcyc = 0, acc = 0;
    bit  done = 0, addr_ok = 1, bubble_ok = 1;
    drive(in);
    d_ready = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      #3;
      if (d_readM || d_writeM) begin
        acc++;
        if (d_readM)  rcyc++;
        if (d_writeM) wcyc++;
        if (d_address !== in.alu) addr_ok = 0;
        if (d_writeM && d_wdata !== in.r2) addr_ok = 0;
        if (RegWrite_out !== 1'b0 || is_wwd_out !== 1'b0 || branch_taken !== 1'b0) bubble_ok = 0;
      end
      d_ready = (acc > 0 && acc == in.lat);
      #1;
      if (mem_stall) stall++;
      else done = 1;
      @(posedge clk);
      #1;
      d_ready = 1'b0;
    end
    check({tag, " completes"}, 32'(done), 32'd1);
    check({tag, " stall cycles"}, 32'(stall), 32'(ex.stall));
    check({tag, " read strobe cycles"}, 32'(rcyc), 32'(ex.rcyc));
    check({tag, " write strobe cycles"}, 32'(wcyc), 32'(ex.wcyc));
    if (ex.stall > 0) begin
      check({tag, " address/wdata held"}, 32'(addr_ok), 32'd1);
      check({tag, " bubble during stall"}, 32'(bubble_ok), 32'd1);
    end
    check({tag, " RegWrite_out"}, 32'(RegWrite_out), 32'(ex.rw));
    check({tag, " is_wwd_out"}, 32'(is_wwd_out), 32'(ex.wwd));
    check({tag, " branch_taken"}, 32'(branch_taken), 32'(ex.bt));
    check({tag, " mem_error"}, 32'(mem_error), 32'(ex.err));
    check({tag, " strobes idle"}, 32'({d_readM, d_writeM}), 32'd0);
    if (ex.chk_data) begin
      check({tag, " wb_data_out"}, 32'(wb_data_out), 32'(ex.wb));
      check({tag, " rd_out"}, 32'(rd_out), 32'(ex.rd));
      check({tag, " wwd_data_out"}, 32'(wwd_data_out), 32'(ex.wdat));
    end
    if (ex.chk_tgt) check({tag, " branch_target"}, 32'(branch_target), 32'(ex.tgt));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " strobes"}, 32'({d_readM, d_writeM}), 32'd0);
    check({tag, " d_address"}, 32'(d_address), 32'd0);
    check({tag, " d_wdata"}, 32'(d_wdata), 32'd0);
    check({tag, " wb_data_out"}, 32'(wb_data_out), 32'd0);
    check({tag, " rd_out"}, 32'(rd_out), 32'd0);
    check({tag, " RegWrite/is_wwd/branch_taken"}, 32'({RegWrite_out, is_wwd_out, branch_taken}), 32'd0);
    check({tag, " wwd_data_out"}, 32'(wwd_data_out), 32'd0);
    check({tag, " branch_target"}, 32'(branch_target), 32'd0);
    check({tag, " mem_error"}, 32'(mem_error), 32'd0);
  endtask

  // Transaction-level expectation: what the stage must show after one instruction
  function automatic exp_t predict(input instr_t in, input logic err_in);
    exp_t e;
    int   n;
    bit   mem = in.mr | in.mw;
    bit   ok  = (in.lat <= MW);
    n = mem ? ((in.lat < MW) ? in.lat : MW) : 0;
    e.stall = n;
    e.wcyc  = in.mw ? n : 0;
    e.rcyc  = (mem && !in.mw) ? n : 0;
    e.wb    = (mem && in.m2r) ? in.rdata : in.alu;
    e.wdat  = in.r1;
    e.tgt   = in.tgt;
    e.rd    = in.rd;
    e.rw    = (!mem || ok) ? in.rw  : 1'b0;
    e.wwd   = (!mem || ok) ? in.wwd : 1'b0;
    e.bt    = !mem && in.bop && in.bcond;
    e.err   = err_in | (mem && !ok);
    e.chk_data = !mem || ok;
    e.chk_tgt  = !mem;
    return e;
  endfunction

  vec_t   vecs[10];
  instr_t nop, ld, ri;
  exp_t   re;
  logic   err_m;

  initial begin
    //            alu      r1       r2       tgt      rdata    rd mr mw rw m2r wwd bop bc lat
    vecs[0] = '{'{16'h1234, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 2'd2, 0,0,1,0,0,0,0, 0},
    //            wb       wdat     tgt      rd  rw wwd bt err st r w  chkd chkt
                '{16'h1234, 16'h5555, 16'h0000, 2'd2, 1,0,0,0, 0,0,0, 1,1}};
    vecs[1] = '{'{16'h0007, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 2'd1, 0,0,0,0,0,1,1, 0},
                '{16'h0007, 16'h0000, 16'h0100, 2'd1, 0,0,1,0, 0,0,0, 1,1}};
    vecs[2] = '{'{16'h0008, 16'h0000, 16'h0000, 16'h0200, 16'h0000, 2'd1, 0,0,0,0,0,1,0, 0},
                '{16'h0008, 16'h0000, 16'h0200, 2'd1, 0,0,0,0, 0,0,0, 1,1}};
    vecs[3] = '{'{16'h0040, 16'h1111, 16'h0000, 16'h0300, 16'hBEEF, 2'd3, 1,0,1,1,0,0,0, 3},
                '{16'hBEEF, 16'h1111, 16'h0000, 2'd3, 1,0,0,0, 3,3,0, 1,0}};
    vecs[4] = '{'{16'h0010, 16'h0000, 16'h00AA, 16'h0000, 16'h0000, 2'd0, 0,1,0,0,0,0,0, 1},
                '{16'h0010, 16'h0000, 16'h0000, 2'd0, 0,0,0,0, 1,0,1, 1,0}};
    vecs[5] = '{'{16'h0020, 16'h0000, 16'h0BB0, 16'h0000, 16'h9999, 2'd1, 1,1,0,0,0,0,0, 2},
                '{16'h0020, 16'h0000, 16'h0000, 2'd1, 0,0,0,0, 2,0,2, 1,0}};
    vecs[6] = '{'{16'h0003, 16'hCAFE, 16'h0000, 16'h0000, 16'h0000, 2'd0, 0,0,0,0,1,0,0, 0},
                '{16'h0003, 16'hCAFE, 16'h0000, 2'd0, 0,1,0,0, 0,0,0, 1,1}};
    vecs[7] = '{'{16'h0050, 16'h0000, 16'h0000, 16'h0000, 16'h1357, 2'd2, 1,0,1,1,0,0,0, 100},
                '{16'h0000, 16'h0000, 16'h0000, 2'd0, 0,0,0,1, 8,8,0, 0,0}};
    vecs[8] = '{'{16'h4321, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'd1, 0,0,1,0,0,0,0, 0},
                '{16'h4321, 16'h0000, 16'h0000, 2'd1, 1,0,0,1, 0,0,0, 1,1}};
    vecs[9] = '{'{16'h0060, 16'h2222, 16'h0000, 16'h0000, 16'h7777, 2'd3, 1,0,1,1,0,0,0, 8},
                '{16'h7777, 16'h2222, 16'h0000, 2'd3, 1,0,0,1, 8,8,0, 1,0}};

    nop = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'd0, 0,0,0,0,0,0,0, 0};
    ld  = '{16'h0040, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 2'd3, 1,0,1,1,0,0,0, 100};

    // Reset with a memory op pending on the inputs: stall must stay low
    drive(ld);
    d_ready = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset mem_stall", 32'(mem_stall), 32'd0);
    check_all_zero("reset");
    reset_n = 1'b0;

    for (int i = 0; i < 10; i++) exec(vecs[i].in, vecs[i].ex, $sformatf("vec%0d", i));

    // Reset in the second ACCESS cycle of a load abandons it and clears mem_error
    drive(ld);
    @(posedge clk); #1;
    check("midreset first access strobe", 32'(d_readM), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    check("midreset stall during reset", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    check_all_zero("midreset");
    reset_n = 1'b0;
    drive(nop);
    d_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #3;
      check("late ready stall", 32'(mem_stall), 32'd0);
      @(posedge clk); #1;
      check("late ready strobes", 32'({d_readM, d_writeM}), 32'd0);
      check("late ready RegWrite_out", 32'(RegWrite_out), 32'd0);
    end
    d_ready = 1'b0;

    // Randomized stream against the transaction model
    err_m = 1'b0;
    for (int i = 0; i < 60; i++) begin
      int kind = $urandom_range(0, 3);
      ri = nop;
      ri.alu   = W'($urandom);
      ri.r1    = W'($urandom);
      ri.r2    = W'($urandom);
      ri.tgt   = W'($urandom);
      ri.rdata = W'($urandom);
      ri.rd    = 2'($urandom);
      ri.rw    = 1'($urandom);
      ri.wwd   = 1'($urandom);
      ri.m2r   = 1'($urandom);
      if (kind == 1) begin
        ri.bop   = 1'b1;
        ri.bcond = 1'($urandom);
      end else if (kind == 2) begin
        ri.mr = 1'b1;
        ri.mw = ($urandom_range(0, 3) == 0);
      end else if (kind == 3) begin
        ri.mw = 1'b1;
      end
      ri.lat = (ri.mr | ri.mw) ? $urandom_range(1, MW + 2) : 0;
      re = predict(ri, err_m);
      err_m = re.err;
      exec(ri, re, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
